muldiv_hilo_sequencer: RTL and testbench

- Multi-cycle multiply/divide unit that owns the architectural HI/LO registers. It replaces single-cycle HI/LO arithmetic in the execute stage.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the pipeline and runs an iterative shift-add multiply or restoring divide.
- Raises an interlock to the hazard unit whenever the pipeline issues a HI/LO read or a new HI/LO op before the current result is committed.

---
 rtl/muldiv_hilo_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_muldiv_hilo_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_hilo_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit that owns the architectural HI/LO
// registers and raises a pipeline interlock while a result is in flight.
//
// Ports:
//   CLK, RESET        clock, asynchronous active-low reset
//   start, op         op request (000 MULT .. 101 MTLO), opA/opB operands
//   flush             synchronous abort of any in-flight op
//   rd_req, rd_sel    MFHI/MFLO request; rd_data = HI (1) or LO (0)
//   stall             busy & (rd_req | start)
//   busy, done        state != IDLE, one-cycle commit pulse
//   HI, LO            committed HI/LO
module muldiv_hilo_sequencer #(
  parameter int RADIX_BITS = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  input  logic        flush,
  input  logic        rd_req,
  input  logic        rd_sel,
  output logic [31:0] rd_data,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int ITER = 32 / RADIX_BITS;
  localparam int SW   = 32 + RADIX_BITS;
  localparam logic [5:0] ITER_C = 6'(ITER);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  // mul: {partial hi, multiplier}; div: {remainder, dividend/quotient}
  logic [63:0] acc_q, acc_d;
  // multiplicand magnitude or divisor magnitude
  logic [31:0] dvs_q, dvs_d;
  logic        isdiv_q, isdiv_d;
  // product / quotient negate
  logic        nega_q, nega_d;
  // remainder negate (dividend sign)
  logic        negr_q, negr_d;
  logic        nowr_q, nowr_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  function automatic logic [31:0] mag(
    input logic [31:0] v,
    input logic        sgn
  );
    return (sgn && v[31]) ? -v : v;
  endfunction

  // Shift-add step: add multiplicand * low digit, shift right by RADIX_BITS.
  logic [RADIX_BITS-1:0] digit;
  logic [SW-1:0]         sum;
  logic [63:0]           mul_nxt;

  always_comb begin
    digit   = acc_q[RADIX_BITS-1:0];
    sum     = SW'(acc_q[63:32]) + SW'(dvs_q) * SW'(digit);
    mul_nxt = {sum, acc_q[31:RADIX_BITS]};
  end

  // Restoring divide, RADIX_BITS quotient bits unrolled per cycle.
  logic [31:0] rem;
  logic [31:0] quo;
  logic [32:0] part;
  logic [63:0] div_nxt;

  always_comb begin
    rem  = acc_q[63:32];
    quo  = acc_q[31:0];
    part = '0;
    for (int i = 0; i < RADIX_BITS; i++) begin
      part = {rem, quo[31]};
      quo  = {quo[30:0], 1'b0};
      if (part >= {1'b0, dvs_q}) begin
        part   = part - {1'b0, dvs_q};
        quo[0] = 1'b1;
      end
      rem = part[31:0];
    end
    div_nxt = {rem, quo};
  end

  // Sign fix-up applied in FIX.
  logic [63:0] prod_fix;
  logic [31:0] rem_fix;
  logic [31:0] quo_fix;

  always_comb begin
    prod_fix = nega_q ? -acc_q : acc_q;
    rem_fix  = negr_q ? -acc_q[63:32] : acc_q[63:32];
    quo_fix  = nega_q ? -acc_q[31:0] : acc_q[31:0];
  end

  logic sgn_op;
  assign sgn_op = ~op[0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    dvs_d   = dvs_q;
    isdiv_d = isdiv_q;
    nega_d  = nega_q;
    negr_d  = negr_q;
    nowr_d  = nowr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          unique case (op)
            3'b000, 3'b001: begin
              dvs_d   = mag(opA, sgn_op);
              acc_d   = {32'h0, mag(opB, sgn_op)};
              nega_d  = sgn_op & (opA[31] ^ opB[31]);
              negr_d  = 1'b0;
              isdiv_d = 1'b0;
              nowr_d  = 1'b0;
              cnt_d   = ITER_C;
              state_d = S_MUL;
            end
            3'b010, 3'b011: begin
              isdiv_d = 1'b1;
              if (opB == 32'h0) begin
                nowr_d  = 1'b1;
                state_d = S_FIX;
              end else begin
                dvs_d   = mag(opB, sgn_op);
                acc_d   = {32'h0, mag(opA, sgn_op)};
                nega_d  = sgn_op & (opA[31] ^ opB[31]);
                negr_d  = sgn_op & opA[31];
                nowr_d  = 1'b0;
                cnt_d   = ITER_C;
                state_d = S_DIV;
              end
            end
            3'b100: hi_d = opA;
            3'b101: lo_d = opA;
            default: ;
          endcase
        end
      end
      S_MUL, S_DIV: begin
        acc_d = (state_q == S_DIV) ? div_nxt
                                   : mul_nxt;
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (!nowr_q) begin
          if (isdiv_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[63:32];
            lo_d = prod_fix[31:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Flush beats everything: no start, no MT write, no commit.
    if (flush) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      dvs_q   <= '0;
      isdiv_q <= 1'b0;
      nega_q  <= 1'b0;
      negr_q  <= 1'b0;
      nowr_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      dvs_q   <= dvs_d;
      isdiv_q <= isdiv_d;
      nega_q  <= nega_d;
      negr_q  <= negr_d;
      nowr_q  <= nowr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign stall   = busy & (rd_req | start);
  assign done    = done_q;
  assign HI      = hi_q;
  assign LO      = lo_q;
  assign rd_data = rd_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_muldiv_hilo_sequencer.sv
// Scoreboard bench for muldiv_hilo_sequencer at RADIX_BITS 1, 2 and 4.
module tb_muldiv_hilo_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st  [3];
  logic [2:0]  opc [3];
  logic [31:0] a_v [3];
  logic [31:0] b_v [3];
  logic        fl  [3];
  logic        rq  [3];
  logic        rs  [3];
  logic [31:0] rdd [3];
  logic        stl [3];
  logic        bsy [3];
  logic        dn  [3];
  logic [31:0] hi_w [3];
  logic [31:0] lo_w [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    muldiv_hilo_sequencer #(.RADIX_BITS(1 << g)) u_dut (
      .CLK(clk), .RESET(rst_n),
      .start(st[g]), .op(opc[g]),
      .opA(a_v[g]), .opB(b_v[g]),
      .flush(fl[g]),
      .rd_req(rq[g]), .rd_sel(rs[g]),
      .rd_data(rdd[g]), .stall(stl[g]),
      .busy(bsy[g]), .done(dn[g]),
      .HI(hi_w[g]), .LO(lo_w[g])
    );
  end

  typedef struct {
    int          k;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_vec = 0;
  int   n_err = 0;

  function automatic void chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endfunction

  // Monitor: every done pulse pops one expectation.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (dn[k]) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious_done dut%0d", k);
        end else begin
          e = sb.pop_front();
          chk("sb_dut", 32'(k), 32'(e.k));
          chk("sb_hi", hi_w[k], e.hi);
          chk("sb_lo", lo_w[k], e.lo);
        end
      end
    end
  end

  task automatic run_op(
    input int          k,
    input logic [2:0]  o,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] hi,
    input logic [31:0] lo,
    input int          lat
  );
    int n;
    int nb;
    bit seen;
    @(negedge clk);
    st[k] = 1'b1; opc[k] = o;
    a_v[k] = a; b_v[k] = b;
    sb.push_back('{k, hi, lo});
    @(posedge clk); #1;
    st[k] = 1'b0;
    n = 0; nb = 0; seen = 1'b0;
    while (!seen && n < 100) begin
      if (bsy[k]) nb++;
      @(posedge clk); #1;
      n++;
      seen = dn[k];
    end
    chk("latency", 32'(n), 32'(lat));
    chk("busy_cycles", 32'(nb), 32'(lat));
    chk("busy_at_done", 32'(bsy[k]), 32'd0);
  endtask

  typedef struct {
    logic [2:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t tbl[12] = '{
    '{3'd0, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE},
    '{3'd1, 32'hFFFFFFFF, 32'h2, 32'h1, 32'hFFFFFFFE},
    '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1},
    '{3'd0, 32'h3, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFF1},
    '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0},
    '{3'd2, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD},
    '{3'd2, 32'h7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD},
    '{3'd2, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h3},
    '{3'd3, 32'h7, 32'h2, 32'h1, 32'h3},
    '{3'd3, 32'hFFFFFFFF, 32'h3, 32'h0, 32'h55555555},
    '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000},
    '{3'd1, 32'h3, 32'h4, 32'h0, 32'hC}
  };

  int nst;

  initial begin
    for (int k = 0; k < 3; k++) begin
      st[k] = 0; opc[k] = 0; a_v[k] = 0; b_v[k] = 0;
      fl[k] = 0; rq[k] = 0; rs[k] = 0;
    end
    a_v[0] = 32'hFFFFFFFF;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hi", hi_w[0], 32'h0);
    chk("rst_lo", lo_w[0], 32'h0);
    chk("rst_busy", 32'(bsy[0]), 32'd0);
    chk("rst_done", 32'(dn[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 12; i++) begin
        run_op(k, tbl[i].o, tbl[i].a, tbl[i].b,
               tbl[i].hi, tbl[i].lo, (32 >> k) + 1);
      end
    end

    // MTHI then divide by zero: HI/LO untouched, 1-cycle busy.
    @(negedge clk);
    st[0] = 1; opc[0] = 3'd4; a_v[0] = 32'h12345678;
    @(posedge clk); #1;
    st[0] = 0;
    chk("mthi_hi", hi_w[0], 32'h12345678);
    chk("mthi_busy", 32'(bsy[0]), 32'd0);
    chk("mthi_done", 32'(dn[0]), 32'd0);
    run_op(0, 3'd2, 32'h5, 32'h0,
           32'h12345678, 32'hC, 1);

    // Interlock: read HI from cycle 2, second start at cycle 5.
    @(negedge clk);
    st[0] = 1; opc[0] = 3'd0;
    a_v[0] = 32'h3; b_v[0] = 32'hFFFFFFFB;
    sb.push_back('{0, 32'hFFFFFFFF, 32'hFFFFFFF1});
    @(posedge clk); #1;
    st[0] = 0;
    nst = 0;
    for (int c = 1; c <= 33; c++) begin
      @(posedge clk); #1;
      if (c == 2) begin
        rq[0] = 1; rs[0] = 1;
      end
      if (c == 5) begin
        st[0] = 1; opc[0] = 3'd5;
        a_v[0] = 32'hAAAA0000;
      end
      #1;
      if (c < 33 && stl[0]) nst++;
      if (c == 33) begin
        chk("stall_drop", 32'(stl[0]), 32'd0);
        chk("stall_done", 32'(dn[0]), 32'd1);
        chk("rd_new_hi", rdd[0], 32'hFFFFFFFF);
      end
    end
    chk("stall_cycles", 32'(nst), 32'd31);
    @(posedge clk); #1;
    st[0] = 0; rq[0] = 0;
    chk("held_mtlo", lo_w[0], 32'hAAAA0000);
    chk("held_busy", 32'(bsy[0]), 32'd0);

    // Flush mid-divide at cycle 10.
    @(negedge clk);
    st[0] = 1; opc[0] = 3'd2;
    a_v[0] = 32'd100; b_v[0] = 32'd7;
    @(posedge clk); #1;
    st[0] = 0;
    repeat (9) @(posedge clk);
    #1;
    fl[0] = 1;
    @(posedge clk); #1;
    fl[0] = 0;
    chk("flush_busy", 32'(bsy[0]), 32'd0);
    repeat (40) @(posedge clk);
    #1;
    chk("flush_hi", hi_w[0], 32'hFFFFFFFF);
    chk("flush_lo", lo_w[0], 32'hAAAA0000);

    // Flush in the FIX cycle suppresses commit.
    @(negedge clk);
    st[0] = 1; opc[0] = 3'd0;
    a_v[0] = 32'd2; b_v[0] = 32'd2;
    @(posedge clk); #1;
    st[0] = 0;
    repeat (32) @(posedge clk);
    #1;
    chk("busy_in_fix", 32'(bsy[0]), 32'd1);
    fl[0] = 1;
    @(posedge clk); #1;
    fl[0] = 0;
    chk("fixflush_busy", 32'(bsy[0]), 32'd0);
    chk("fixflush_done", 32'(dn[0]), 32'd0);
    chk("fixflush_lo", lo_w[0], 32'hAAAA0000);

    // Start together with flush in IDLE does nothing.
    @(negedge clk);
    st[0] = 1; opc[0] = 3'd4;
    a_v[0] = 32'hDEADBEEF; fl[0] = 1;
    @(posedge clk); #1;
    chk("flushmt_hi", hi_w[0], 32'hFFFFFFFF);
    opc[0] = 3'd0;
    @(posedge clk); #1;
    chk("flushst_busy", 32'(bsy[0]), 32'd0);
    st[0] = 0; fl[0] = 0;

    // Asynchronous reset mid-multiply.
    @(negedge clk);
    st[0] = 1; opc[0] = 3'd1;
    a_v[0] = 32'hFFFFFFFF; b_v[0] = 32'hFFFFFFFF;
    @(posedge clk); #1;
    st[0] = 0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_hi", hi_w[0], 32'h0);
    chk("arst_lo", lo_w[0], 32'h0);
    chk("arst_busy", 32'(bsy[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 3'd1, 32'h3, 32'h4, 32'h0, 32'hC, 33);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
